// File: rtl/pipeline_defs.sv
// Shared definitions for the ID-stage branch resolution path: FSM encoding and register-file constants.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pipeline_defs;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_WAIT = 1'b1;

    typedef enum logic {
        RUN  = ST_RUN,
        WAIT = ST_WAIT
    } state_e;

endpackage

// File: rtl/hazard_need_calc.sv
// Stall-cycle requirement for an ID-stage branch from EX/MEM producers of its comparator operands.
// Latency: combinational.
// Backpressure: none; the result is consumed the same cycle by the branch FSM.
module hazard_need_calc #(
    parameter int REG_W      = pipeline_defs::REG_W,
    parameter int ALU_STALL  = 1,
    parameter int LOAD_STALL = 2,
    parameter int CNT_W      = 2
) (
    input  logic             br,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_memread,
    input  logic [REG_W-1:0] mem_rd,
    output logic [CNT_W-1:0] need
);
    import pipeline_defs::*;

    localparam logic [CNT_W-1:0] NEED_EX_LD  = CNT_W'(LOAD_STALL);
    localparam logic [CNT_W-1:0] NEED_EX_ALU = CNT_W'(ALU_STALL);
    localparam logic [CNT_W-1:0] NEED_MEM_LD = CNT_W'(LOAD_STALL - 1);

    // $0 is hardwired, so a producer targeting it never creates a dependency.
    function automatic logic [CNT_W-1:0] src_need(input logic [REG_W-1:0] s);
        logic [CNT_W-1:0] n;
        n = '0;
        if (s != REG_W'(REG_ZERO)) begin
            if (ex_regwrite && (ex_rd == s))
                n = ex_memread ? NEED_EX_LD : NEED_EX_ALU;
            if (mem_memread && (mem_rd == s) && (NEED_MEM_LD > n))
                n = NEED_MEM_LD;
        end
        return n;
    endfunction

    logic [CNT_W-1:0] need_rs;
    logic [CNT_W-1:0] need_rt;

    always_comb begin
        need_rs = src_need(id_rs);
        need_rt = src_need(id_rt);
        need    = '0;
        if (br)
            need = (need_rs > need_rt) ? need_rs : need_rt;
    end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch/jump sequencer: stalls on operand hazards, then drives pc_sel and IF/ID flush; optional BRANCH_STATS_EN counters.
// Latency: resolution is same-cycle when no hazard; a hazard costs one detect cycle plus need WAIT cycles.
// Backpressure: holds PC and IF/ID (pc_write/ifid_write low) and bubbles ID/EX while stalling.
module branch_hazard_ctrl #(
    parameter int REG_W      = pipeline_defs::REG_W,
    parameter int ALU_STALL  = 1,
    parameter int LOAD_STALL = 2,
    parameter int CNT_W      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_brancheq,
    input  logic             id_branchneq,
    input  logic             id_jump,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             cmp_result,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_memread,
    input  logic [REG_W-1:0] mem_rd,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pc_sel,
    output logic             stall_active
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]      stat_taken,
    output logic [15:0]      stat_nottaken,
    output logic [15:0]      stat_stall
`endif
);
    import pipeline_defs::*;

    state_e           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] need;
    logic [CNT_W-1:0] need_eff;
    logic             br;
    logic             taken;
    logic             resolve;

    assign br = id_brancheq | id_branchneq;

    hazard_need_calc #(
        .REG_W      (REG_W),
        .ALU_STALL  (ALU_STALL),
        .LOAD_STALL (LOAD_STALL),
        .CNT_W      (CNT_W)
    ) u_need (
        .br          (br),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_regwrite (ex_regwrite),
        .ex_memread  (ex_memread),
        .ex_rd       (ex_rd),
        .mem_memread (mem_memread),
        .mem_rd      (mem_rd),
        .need        (need)
    );

    // A jump never reads registers, so it overrides any branch flag decoded alongside it.
    assign need_eff = id_jump ? '0 : need;
    assign taken    = id_jump | (id_brancheq & cmp_result) | (id_branchneq & ~cmp_result);
    assign resolve  = (state == RUN) && (need_eff == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        pc_sel       = 1'b0;
        stall_active = 1'b0;
        case (state)
            RUN: begin
                if (need_eff != '0) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    state_nxt   = WAIT;
                    cnt_nxt     = need_eff - CNT_W'(1);
                end else begin
                    pc_sel     = taken;
                    ifid_flush = taken;
                end
            end
            WAIT: begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_bubble  = 1'b1;
                stall_active = 1'b1;
                if (cnt == '0)
                    state_nxt = RUN;
                else
                    cnt_nxt = cnt - CNT_W'(1);
            end
            default: state_nxt = RUN;
        endcase
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_taken    <= '0;
            stat_nottaken <= '0;
            stat_stall    <= '0;
        end else begin
            if (resolve && taken && (stat_taken != 16'hFFFF))
                stat_taken <= stat_taken + 16'd1;
            if (resolve && br && !taken && (stat_nottaken != 16'hFFFF))
                stat_nottaken <= stat_nottaken + 16'd1;
            if ((state == WAIT) && (stat_stall != 16'hFFFF))
                stat_stall <= stat_stall + 16'd1;
        end
    end
`endif

endmodule

// File: doc/branch_hazard_ctrl.md
Name: branch_hazard_ctrl

Overview:
Sequencing controller for the ID-stage branch/jump resolution path of the 5-stage MIPS pipeline.
- Detects data hazards on the ID comparator operands and stalls PC and IF/ID for a counted number of cycles.
- Inserts ID/EX bubbles during the stall.
- Once the operands are valid, issues the PC-source select and the IF/ID flush for taken branches and jumps.
- Sits between the hazard unit and the PC mux.

Parameters:
- REG_W, 5, register-index width.
- ALU_STALL, 1, stall cycles when the producer is an ALU instruction in EX.
- LOAD_STALL, 2, stall cycles when the producer is a load in EX. A load in MEM costs LOAD_STALL-1.
- CNT_W, 2, stall-counter width. Must hold LOAD_STALL.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_brancheq  in  1  beq decoded in ID.
- id_branchneq  in  1  bne decoded in ID.
- id_jump  in  1  j/jal decoded in ID.
- id_rs, id_rt  in  REG_W  comparator source registers.
- cmp_result  in  1  ID comparator equal flag.
- ex_regwrite, ex_memread  in  1  EX-stage control.
- ex_rd  in  REG_W  EX destination.
- mem_memread  in  1  MEM-stage load flag.
- mem_rd  in  REG_W  MEM destination.
- pc_write  out  1  PC enable.
- ifid_write  out  1  IF/ID enable.
- ifid_flush  out  1  zero IF/ID on next edge.
- idex_bubble  out  1  zero ID/EX control on next edge.
- pc_sel  out  1  1 = take branch/jump target.
- stall_active  out  1  FSM in WAIT.

Behaviour:
- States:
  - RUN: resolve or detect.
  - WAIT: counting down stall cycles.
- Registered: state, cnt[CNT_W-1:0]. Outputs are combinational from state, cnt and inputs.
- Reset (async, rst_n=0): state=RUN, cnt=0.
  - With all inputs 0: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, pc_sel=0, stall_active=0.
  - Reset mid-WAIT aborts the stall immediately. The pending branch is re-evaluated from RUN after release.
- br = id_brancheq | id_branchneq.
- Hazard applies to register 0 never. For a source s in {rs, rt} with s != 0:
  - hazEX_ld: br & ex_regwrite & ex_memread & ex_rd==s → need = LOAD_STALL.
  - hazEX_alu: br & ex_regwrite & !ex_memread & ex_rd==s → need = ALU_STALL.
  - hazMEM_ld: br & mem_memread & mem_rd==s → need = LOAD_STALL-1.
  - If several apply, need = maximum.
- RUN, need>0:
  - pc_write=0, ifid_write=0, idex_bubble=1, pc_sel=0, ifid_flush=0.
  - Next state WAIT, cnt=need-1.
- RUN, need==0: resolve.
  - taken = id_jump | (id_brancheq & cmp_result) | (id_branchneq & !cmp_result).
  - pc_sel=taken, ifid_flush=taken, pc_write=1, ifid_write=1. Stay in RUN.
- WAIT:
  - pc_write=0, ifid_write=0, idex_bubble=1, pc_sel=0, stall_active=1.
  - cnt==0 → RUN; otherwise cnt decrements.
  - Branch/ex/mem inputs are ignored in WAIT.
  - Stall length is exactly need cycles. The instruction is then resolved in RUN on the following cycle, with hazards re-checked.
- Jumps never stall. id_jump takes priority over branch flags when both are asserted (illegal decode): pc_sel=1, no stall.
- Simultaneous brancheq & branchneq: taken if either condition holds.
- cmp_result is sampled only in RUN with need==0.

Optional Feature:
- BRANCH_STATS_EN defined:
  - Adds outputs stat_taken[15:0], stat_nottaken[15:0] and stat_stall[15:0].
  - These count resolved taken branches/jumps, resolved not-taken branches, and WAIT cycles respectively.
  - Counters saturate at 16'hFFFF and reset to 0 on rst_n.
- BRANCH_STATS_EN undefined: these ports and registers are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package / include (pipeline_defs):
  - state encoding localparams ST_RUN=1'b0, ST_WAIT=1'b1.
  - REG_W default.
  - REG_ZERO = 0.
- Sub-module hazard_need_calc (combinational): computes need from the ID/EX/MEM fields. Keeps the FSM file small and testable in isolation.

Test Plan:
1. Reset then idle: rst_n low 2 cycles, release → pc_write=1, ifid_write=1, pc_sel=0, ifid_flush=0, stall_active=0.
2. beq rs=rt=8, cmp_result=1, no hazard → same cycle pc_sel=1, ifid_flush=1, no stall. bne with cmp_result=1 → pc_sel=0.
3. Load to $9 in EX, beq using $9 → stall_active high exactly 2 cycles with pc_write=0 and idex_bubble=1. Third cycle: RUN resolves with the then-presented cmp_result.
4. ALU to $10 in EX, bne using $10 → 1 stall cycle. Load to $10 in MEM → 1 stall cycle. Producer writing $0 → no stall.
5. id_jump=1 with ex load hazard on rs → no stall, pc_sel=1, ifid_flush=1.
6. Assert rst_n=0 in the middle of a 2-cycle WAIT → immediately state RUN, stall_active=0. With BRANCH_STATS_EN: stat_stall=0 after reset, and the counter saturates when forced near 16'hFFFF.
